// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, FSM state type and frame-load helper for the UART transmitter.
// Defining UART_PARITY_EN adds an even-parity bit between d7 and the stop bit.
package uart_pkg;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int CLKS_PER_BIT_DEF = 217;
   localparam int SHREG_W = FRAME_BITS - 1;
   localparam int BIT_W = $clog2(FRAME_BITS);
   typedef enum logic {IDLE, SEND} state_t;
   // Start bit sits in the LSB; the stop bit is supplied by the ones shifted in at the MSB.
   function automatic logic [SHREG_W-1:0] frame_load(input logic [7:0] d);
`ifdef UART_PARITY_EN
      return {^d, d, 1'b0};
`else
      return {d, 1'b0};
`endif
   endfunction
endpackage

// File: rtl/uart_tx_shreg.sv
// uart_tx_shreg: right shift register with parallel load and 1-bit MSB insert; resets to all ones.
module uart_tx_shreg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic         i_msb,
   input  logic [W-1:0] i_din,
   output logic         o_lsb
);
   logic [W-1:0] r_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_q <= '1;
      else if (i_load) r_q <= i_din;
      else if (i_shift) r_q <= {i_msb, r_q[W-1:1]};
   assign o_lsb = r_q[0];
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 UART transmitter (8E1 with UART_PARITY_EN) with baud counter, bit counter and frame FSM.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   state_t           r_state;
   logic [CNT_W-1:0] r_baud;
   logic [BIT_W-1:0] r_bit;
   logic             w_tick;
   logic             w_load;
   logic             w_last;
   assign in_ready = (r_state == IDLE);
   assign busy     = (r_state == SEND);
   assign w_load   = in_valid && in_ready;
   assign w_tick   = busy && (r_baud == CNT_W'(CLKS_PER_BIT - 1));
   assign w_last   = (r_bit == BIT_W'(FRAME_BITS - 1));
   uart_tx_shreg #(.W(SHREG_W)) u_shreg (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_shift(w_tick),
      .i_msb  (1'b1),
      .i_din  (frame_load(in_data)),
      .o_lsb  (tx)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
      end else if (r_state == IDLE) begin
         r_baud <= '0;
         r_bit  <= '0;
         if (in_valid) r_state <= SEND;
      end else if (w_tick) begin
         r_baud <= '0;
         r_bit  <= w_last ? '0 : r_bit + BIT_W'(1);
         if (w_last) r_state <= IDLE;
      end else r_baud <= r_baud + CNT_W'(1);
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized scoreboard bench; a timing model queues accepted bytes, a line monitor decodes and compares.
module tb_uart_tx_frame;
   import uart_pkg::*;
   localparam int N  = 4;
   localparam int FB = FRAME_BITS;
   logic       clk = 0;
   logic       rst_n = 0;
   logic       in_valid = 0;
   logic [7:0] in_data = 0;
   logic       in_ready, tx, busy;
   int         tests = 0, fails = 0;
   int         cyc = 0;
   int         acc = 0;
   bit         have = 0;
   int         acc_q[$];
   logic [7:0] dat_q[$];
   bit         act = 0;
   int         mb = 0, mc = 0;
   logic [7:0] md = 0;

   uart_tx_frame #(.CLKS_PER_BIT(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, a, e);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endtask

   // The line is free once FB bit periods have elapsed since the last accept edge.
   function automatic bit exp_ready();
      return !have || (cyc >= acc + FB * N);
   endfunction

   // Bit i of the frame as seen on the line: start, d0..d7, optional even parity, stop.
   function automatic logic exp_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return logic'((d >> (i - 1)) & 8'd1);
      if (FB == 11 && i == 9) return logic'($countones(d) % 2);
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         have = 0;
         acc_q.delete();
         dat_q.delete();
      end else begin
         check("in_ready", in_ready, exp_ready());
         check("busy", busy, !exp_ready());
         if (in_valid && exp_ready()) begin
            acc = cyc + 1;
            have = 1;
            acc_q.push_back(acc);
            dat_q.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         act = 0;
         check("tx_in_reset", tx, 1);
      end else begin
         if (!act) begin
            if (tx === 1'b0) begin
               if (acc_q.size() == 0) fail_now("unexpected_start");
               else begin
                  check("start_time", cyc, acc_q.pop_front());
                  md = dat_q.pop_front();
                  act = 1;
                  mb = 0;
                  mc = 0;
               end
            end else check("idle_tx", tx, 1);
         end
         if (act) begin
            check($sformatf("bit%0d_of_%02h", mb, md), tx, exp_bit(md, mb));
            mc++;
            if (mc == N) begin
               mc = 0;
               mb++;
               if (mb == FB) act = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit hold);
      int k;
      @(posedge clk);
      #1;
      in_data = d;
      in_valid = 1;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (k == 2000) fail_now("send_timeout");
      @(posedge clk);
      #1;
      if (!hold) in_valid = 0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         #1;
         if (!act && acc_q.size() == 0 && in_ready) break;
      end
      if (k == 2000) fail_now("drain_timeout");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (20) @(posedge clk);
      send(8'h55, 0);
      drain();
      send(8'hA3, 1);
      send(8'h0F, 0);
      drain();
      send(8'hC6, 0);
      repeat (8) @(posedge clk);
      #1;
      in_data = 8'hFF;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      drain();
      repeat (5) @(posedge clk);
      send(8'hA5, 0);
      repeat (4 * N + 1) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("async_rst_tx", tx, 1);
      check("async_rst_ready", in_ready, 1);
      check("async_rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1;
      repeat (20) @(posedge clk);
      send(8'h07, 0);
      drain();
      for (int i = 0; i < 40; i++) begin
         bit hold;
         hold = (i != 39) && ($urandom_range(0, 2) == 0);
         send(8'($urandom), hold);
         if (!hold && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
            in_data = 8'($urandom);
            in_valid = 1;
            @(posedge clk);
            #1 in_valid = 0;
         end
         if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();
      check("queue_empty", acc_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
